// File: rtl/vend_txn_ctrl.sv
// Vending purchase sequencer: selection -> inventory lookup -> coin collection -> dispense -> payout.
// Optional build macro VEND_COIN_FILTER_EN accepts only standard coin values; all other coins are refunded.
module vend_txn_ctrl #(
    parameter int ITEM_AW     = 10,
    parameter int QTY_W       = 8,
    parameter int CUR_W       = 8,
    parameter int TOT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [ITEM_AW-1:0] sel_item,
    input  logic [QTY_W-1:0]   sel_qty,
    input  logic               coin_valid,
    input  logic [CUR_W-1:0]   coin_value,
    input  logic               cancel,
    output logic               inv_rd_req,
    output logic [ITEM_AW-1:0] inv_rd_addr,
    input  logic               inv_rd_valid,
    input  logic [CUR_W-1:0]   inv_rd_price,
    input  logic [QTY_W-1:0]   inv_rd_stock,
    output logic               disp_en,
    output logic [ITEM_AW-1:0] disp_item,
    output logic [QTY_W-1:0]   disp_qty,
    output logic [QTY_W-1:0]   disp_avail,
    output logic [CUR_W-1:0]   disp_price,
    output logic [TOT_W-1:0]   disp_total,
    input  logic               disp_ok,
    input  logic [TOT_W-1:0]   disp_change,
    output logic               inv_wr_en,
    output logic [ITEM_AW-1:0] inv_wr_addr,
    output logic [QTY_W-1:0]   inv_wr_stock,
    output logic               change_valid,
    output logic [TOT_W-1:0]   change_amount,
    input  logic               change_ready,
    output logic               busy,
    output logic               timeout_evt
);
    // state   | meaning
    // IDLE    | waiting for a selection, sel_ready high
    // LOOKUP  | price/stock read outstanding
    // COLLECT | accumulating coins, inactivity timer running
    // EVAL    | disp_en pulse to the dispense datapath
    // WAIT    | datapath result sampled
    // UPDATE  | stock write-back pulse
    // PAYOUT  | change offered until accepted
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_COLLECT, S_EVAL, S_WAIT, S_UPDATE, S_PAYOUT
    } state_t;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [ITEM_AW-1:0] item_q;
    logic [QTY_W-1:0]   qty_q;
    logic [CUR_W-1:0]   price_q;
    logic [QTY_W-1:0]   stock_q;
    logic [TOT_W-1:0]   total;
    logic [TOT_W-1:0]   reject_sum;
    logic [TMR_W-1:0]   timer;

    logic               coin_add;
    logic               coin_rej;
    logic [TOT_W-1:0]   coin_ext;
    logic [TOT_W-1:0]   total_nxt;
    logic [TOT_W-1:0]   reject_nxt;
    logic [TOT_W-1:0]   refund_amt;
    logic [TOT_W-1:0]   target;

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TOT_W] ? '1 : s[TOT_W-1:0];
    endfunction

`ifdef VEND_COIN_FILTER_EN
    logic coin_ok;
    assign coin_ok  = (coin_value == CUR_W'(1))  || (coin_value == CUR_W'(2))  ||
                      (coin_value == CUR_W'(5))  || (coin_value == CUR_W'(10)) ||
                      (coin_value == CUR_W'(20)) || (coin_value == CUR_W'(50)) ||
                      (coin_value == CUR_W'(100));
    assign coin_add = coin_valid && coin_ok;
    assign coin_rej = coin_valid && !coin_ok;
`else
    assign coin_add = coin_valid && (coin_value != '0);
    assign coin_rej = 1'b0;
`endif

    assign coin_ext   = TOT_W'(coin_value);
    assign total_nxt  = coin_add ? sat_add(total, coin_ext) : total;
    assign reject_nxt = coin_rej ? sat_add(reject_sum, coin_ext) : reject_sum;
    assign refund_amt = sat_add(total_nxt, reject_nxt);
    assign target     = TOT_W'(price_q) * TOT_W'(qty_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            item_q        <= '0;
            qty_q         <= '0;
            price_q       <= '0;
            stock_q       <= '0;
            total         <= '0;
            reject_sum    <= '0;
            timer         <= '0;
            sel_ready     <= 1'b0;
            inv_rd_req    <= 1'b0;
            inv_rd_addr   <= '0;
            disp_en       <= 1'b0;
            disp_item     <= '0;
            disp_qty      <= '0;
            disp_avail    <= '0;
            disp_price    <= '0;
            disp_total    <= '0;
            inv_wr_en     <= 1'b0;
            inv_wr_addr   <= '0;
            inv_wr_stock  <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            busy          <= 1'b0;
            timeout_evt   <= 1'b0;
        end else begin
            inv_rd_req  <= 1'b0;
            disp_en     <= 1'b0;
            inv_wr_en   <= 1'b0;
            timeout_evt <= 1'b0;
            case (state)
                S_IDLE: begin
                    sel_ready <= 1'b1;
                    if (sel_ready && sel_valid && sel_qty != '0) begin
                        item_q      <= sel_item;
                        qty_q       <= sel_qty;
                        inv_rd_req  <= 1'b1;
                        inv_rd_addr <= sel_item;
                        sel_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cancel) begin
                        sel_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (inv_rd_valid) begin
                        price_q <= inv_rd_price;
                        stock_q <= inv_rd_stock;
                        timer   <= TMR_LOAD;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    total      <= total_nxt;
                    reject_sum <= reject_nxt;
                    if (coin_add || coin_rej)
                        timer <= TMR_LOAD;
                    else if (timer != '0)
                        timer <= timer - TMR_W'(1);
                    // a coin arriving on the terminal count restarts the timer instead of timing out
                    if (cancel || (timer == '0 && !(coin_add || coin_rej))) begin
                        timeout_evt <= !cancel;
                        if (refund_amt != '0) begin
                            change_amount <= refund_amt;
                            change_valid  <= 1'b1;
                            state         <= S_PAYOUT;
                        end else begin
                            sel_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else if (total_nxt >= target) begin
                        disp_en    <= 1'b1;
                        disp_item  <= item_q;
                        disp_qty   <= qty_q;
                        disp_avail <= stock_q;
                        disp_price <= price_q;
                        disp_total <= total_nxt;
                        state      <= S_EVAL;
                    end
                end
                S_EVAL: state <= S_WAIT;
                S_WAIT: begin
                    change_amount <= sat_add(disp_change, reject_sum);
                    disp_item     <= '0;
                    disp_qty      <= '0;
                    disp_avail    <= '0;
                    disp_price    <= '0;
                    disp_total    <= '0;
                    if (disp_ok) begin
                        inv_wr_en    <= 1'b1;
                        inv_wr_addr  <= item_q;
                        inv_wr_stock <= stock_q - qty_q;
                        state        <= S_UPDATE;
                    end else begin
                        change_valid <= 1'b1;
                        state        <= S_PAYOUT;
                    end
                end
                S_UPDATE: begin
                    if (change_amount != '0) begin
                        change_valid <= 1'b1;
                        state        <= S_PAYOUT;
                    end else begin
                        total      <= '0;
                        reject_sum <= '0;
                        sel_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_PAYOUT: begin
                    if (change_ready) begin
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                        total         <= '0;
                        reject_sum    <= '0;
                        sel_ready     <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
